// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Purpose: Shared definitions for the ALU adder datapath: stage-count helper,
//          status flag layout and flag bit indices.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Bit positions of the flags inside alu_flags_t.
  localparam int FLG_Z = 0;
  localparam int FLG_V = 1;
  localparam int FLG_C = 2;

  // Packed status flags: carry, signed overflow, zero (c is the MSB).
  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } alu_flags_t;

  // Number of lookahead blocks, one per pipeline stage.
  function automatic int n_stages(input int width, input int block);
    return width / block;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// ============================================================================
// Module : cla_block
// Purpose: BLOCK-bit combinational carry-lookahead slice.
// Ports  : a, b   - block operands
//          cin    - carry into bit 0
//          sum    - block sum
//          cout   - carry out of the block MSB
//          g, p   - group generate / group propagate of the whole block
//          c_msb  - carry into the block MSB (used for signed overflow)
// Rev    : 1.0  initial release
// ============================================================================
module cla_block
  import alu_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p,
  output logic             c_msb
);

  logic [BLOCK-1:0] gen;
  logic [BLOCK-1:0] prop;
  logic [BLOCK:0]   carry;
  logic             gg;
  logic             pp;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each carry is formed from the prefix group (G,P) of bits [i:0] and the
  // block carry-in, so no carry depends on the previous bit's carry.
  always_comb begin
    gg       = 1'b0;
    pp       = 1'b1;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      gg           = gen[i] | (prop[i] & gg);
      pp           = prop[i] & pp;
      carry[i+1]   = gg | (pp & cin);
    end
  end

  assign sum   = prop ^ carry[BLOCK-1:0];
  assign cout  = carry[BLOCK];
  assign g     = gg;
  assign p     = pp;
  assign c_msb = carry[BLOCK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_cla_adder
// Purpose: Pipelined carry-lookahead adder/subtractor. One BLOCK-bit lookahead
//          slice per stage, carry registered between stages, STAGES-cycle
//          latency, one result per cycle, valid/ready with backpressure.
// Ports  : clk, rst_n            - clock, async active-low reset
//          in_valid/in_ready     - input handshake
//          in_a, in_b, in_cin    - operands and carry/borrow in
//          in_sub                - 0: A+B+cin, 1: A-B-cin
//          in_tag                - user tag carried with the operation
//          out_valid/out_ready   - output handshake
//          out_sum               - result
//          out_cout/ovf/zero     - carry out, signed overflow, zero
//          out_tag               - tag of the presented result
// Rev    : 1.0  initial release
// ============================================================================
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = n_stages(WIDTH, BLOCK);
  localparam int LAST   = STAGES - 1;

  if ((BLOCK < 1) || (BLOCK > WIDTH) || (WIDTH % BLOCK != 0) || (TAG_W < 1)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK and TAG_W >= 1");
  end

  logic adv;

  // Stage inputs: stage 0 sees the conditioned ports, stage k>0 sees stage k-1.
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];
  logic [TAG_W-1:0] tag_in [STAGES];

  logic [BLOCK-1:0] blk_sum  [STAGES];
  logic             blk_cout [STAGES];
  logic             blk_g    [STAGES];
  logic             blk_p    [STAGES];
  logic             blk_cmsb [STAGES];

  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_nx [STAGES];
  alu_flags_t       flags_nx;

  // Stage registers. a_q/b_q skew the not-yet-added upper operand bits, s_q
  // de-skews the already resolved lower sum slices.
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  alu_flags_t       flags_q;

  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // A - B - borrow == A + ~B + ~borrow
      assign a_in[k]   = in_a;
      assign b_in[k]   = in_sub ? ~in_b : in_b;
      assign c_in[k]   = in_sub ^ in_cin;
      assign s_in[k]   = '0;
      assign v_in[k]   = in_valid;
      assign tag_in[k] = in_tag;
    end else begin : g_body
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign c_in[k]   = c_q[k-1];
      assign s_in[k]   = s_q[k-1];
      assign v_in[k]   = v_q[k-1];
      assign tag_in[k] = tag_q[k-1];
    end

    cla_block #(
      .BLOCK (BLOCK)
    ) u_blk (
      .a     (a_in[k][k*BLOCK +: BLOCK]),
      .b     (b_in[k][k*BLOCK +: BLOCK]),
      .cin   (c_in[k]),
      .sum   (blk_sum[k]),
      .cout  (blk_cout[k]),
      .g     (blk_g[k]),
      .p     (blk_p[k]),
      .c_msb (blk_cmsb[k])
    );

    // The block carry-out is taken from the group terms; the ripple form
    // coming out of the slice must agree with it.
    always_comb begin
      assert (blk_cout[k] == (blk_g[k] | (blk_p[k] & c_in[k])));
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k]                    = s_in[k];
      s_nx[k][k*BLOCK +: BLOCK]  = blk_sum[k];
      c_nx[k]                    = blk_g[k] | (blk_p[k] & c_in[k]);
    end
    flags_nx   = '0;
    flags_nx.c = c_nx[LAST];
    flags_nx.v = blk_cmsb[LAST] ^ c_nx[LAST];
    flags_nx.z = ~|s_nx[LAST];
  end

  // Every stage, valid bits included, moves only on adv so a stalled output
  // freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        tag_q[k] <= '0;
      end
      flags_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_in[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        s_q[k]   <= s_nx[k];
        c_q[k]   <= c_nx[k];
        tag_q[k] <= tag_in[k];
      end
      flags_q <= flags_nx;
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = s_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_cout  = flags_q[FLG_C];
  assign out_ovf   = flags_q[FLG_V];
  assign out_zero  = flags_q[FLG_Z];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_pipelined_cla_adder
// Purpose: Directed self-checking bench for pipelined_cla_adder
//          (WIDTH=32, BLOCK=8, latency 4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic [3:0]  out_tag;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] ST_A   [8] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                         32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
  localparam logic [31:0] ST_EXP [8] = '{32'h01010101, 32'h12121212, 32'h23232323, 32'h34343434,
                                         32'h45454545, 32'h56565656, 32'h67676767, 32'h78787878};
  // 0x100 - tag for tags 8..11
  localparam logic [31:0] BP_EXP [4] = '{32'h000000F8, 32'h000000F7, 32'h000000F6, 32'h000000F5};

  pipelined_cla_adder #(
    .WIDTH (32),
    .BLOCK (8),
    .TAG_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [3:0] tag);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_tag   = tag;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  // Single op with out_ready=1; checks the exact latency and all result fields.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [3:0] tag,
                         input logic [31:0] es, input logic ec, input logic ev, input logic ez);
    out_ready = 1'b1;
    @(negedge clk);
    check({name, " in_ready"}, in_ready, 1);
    drive(1'b1, a, b, cin, sub, tag);
    @(negedge clk);
    idle();
    check({name, " lat1"}, out_valid, 0);
    @(negedge clk);
    check({name, " lat2"}, out_valid, 0);
    @(negedge clk);
    check({name, " lat3"}, out_valid, 0);
    @(negedge clk);
    check({name, " valid"}, out_valid, 1);
    check({name, " sum"},   out_sum,   es);
    check({name, " cout"},  out_cout,  ec);
    check({name, " ovf"},   out_ovf,   ev);
    check({name, " zero"},  out_zero,  ez);
    check({name, " tag"},   out_tag,   tag);
    @(negedge clk);
    check({name, " drained"}, out_valid, 0);
  endtask

  initial begin
    int acc;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_sum",   out_sum,   0);
    check("rst out_cout",  out_cout,  0);
    check("rst out_ovf",   out_ovf,   0);
    check("rst out_zero",  out_zero,  0);
    check("rst out_tag",   out_tag,   0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 1);

    // Directed add/sub vectors
    run_one("add ffff+1",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 4'd3, 32'h00010000, 1'b0, 1'b0, 1'b0);
    run_one("add ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd4, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_one("add wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd5, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_one("add cin",     32'h12345678, 32'h11111111, 1'b1, 1'b0, 4'd6, 32'h2345678A, 1'b0, 1'b0, 1'b0);
    run_one("sub 5-7",     32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub min-1",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'd8, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_one("sub borrow",  32'h0000000A, 32'h00000003, 1'b1, 1'b1, 4'd9, 32'h00000006, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream, results on consecutive cycles in order
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c < 8) drive(1'b1, ST_A[c], 32'h01010101, 1'b0, 1'b0, c[3:0]);
      else idle();
      check("stream in_ready", in_ready, 1);
      if (c >= 4 && c < 12) begin
        check("stream valid", out_valid, 1);
        check("stream sum",   out_sum,   ST_EXP[c-4]);
        check("stream tag",   out_tag,   c - 4);
      end else begin
        check("stream idle", out_valid, 0);
      end
    end

    // Backpressure: out_ready low, input kept offered until the pipe fills
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        check("bp in_ready", in_ready, 0);
        check("bp valid",    out_valid, 1);
        check("bp sum hold", out_sum,   32'h000000F8);
        check("bp tag hold", out_tag,   8);
        check("bp c hold",   out_cout,  1);
      end
      drive(1'b1, 32'h00000100, 32'(8 + acc), 1'b0, 1'b1, 4'(8 + acc));
      if (in_ready) acc++;
    end
    check("bp accepted", acc, 4);
    // Release: tag 8 is consumed at the next edge, 9..11 follow back-to-back
    out_ready = 1'b1;
    idle();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      if (r < 3) begin
        check("rel valid", out_valid, 1);
        check("rel sum",   out_sum,   BP_EXP[r+1]);
        check("rel tag",   out_tag,   9 + r);
        check("rel cout",  out_cout,  1);
      end else begin
        check("rel empty", out_valid, 0);
      end
    end

    // Reset with ops in flight
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) drive(1'b1, 32'(c + 1), 32'(c + 1), 1'b0, 1'b0, 4'(c + 1));
      else idle();
    end
    check("pre-rst valid", out_valid, 1);
    check("pre-rst sum",   out_sum,   2);
    check("pre-rst tag",   out_tag,   1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst valid", out_valid, 0);
    check("async rst sum",   out_sum,   0);
    check("async rst tag",   out_tag,   0);
    check("async rst ready", in_ready,  1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no stale", out_valid, 0);
    end
    run_one("after rst", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 4'd5, 32'h00000007, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the 32-bit ALU datapath.
- Splits a WIDTH-bit operation into STAGES = WIDTH/BLOCK lookahead blocks, one block per pipeline stage.
- The carry is registered between stages, giving one result per cycle at a latency of STAGES cycles.
- Adds a subtract mode, status flags (carry, signed overflow, zero), a pass-through tag, and a valid/ready handshake with backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, bits resolved per stage by one lookahead block; 1..WIDTH.
- TAG_W, 4, width of the user tag carried alongside each operation; at least 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts the operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0 = A+B+cin, 1 = A-B-cin
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- out_ovf  out  1  signed two's-complement overflow
- out_zero  out  1  out_sum == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync deassert at the next clk edge):
  - All stage valid bits clear and all data/flag registers clear.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_tag=0.
  - in_ready=1 from the first cycle after reset.
- Operand conditioning at accept:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? ~in_cin : in_cin, so that A-B-borrow = A + ~B + ~borrow.
- Stage k (0..STAGES-1):
  - Computes bits [k*BLOCK +: BLOCK] combinationally from the registered block operands and the registered carry.
  - Registers the sum slice and the carry out.
  - Upper operand slices travel in skew registers; completed lower sum slices travel in de-skew registers.
  - Only one block's carry chain lies in any register-to-register path.
- Global advance: adv = !out_valid | out_ready. All stage registers, including the valid bits, load only when adv=1; otherwise every stage holds.
- Handshake:
  - in_ready = adv, so in_ready is combinational from out_ready and out_valid.
  - Accept occurs when in_valid & in_ready.
  - A cycle with adv=1 and in_valid=0 inserts a bubble: the valid bit is cleared and the data is don't-care.
- Latency: a result accepted at edge N presents out_valid=1 after edge N+STAGES-1, i.e. it is visible in the cycle following that edge. STAGES=1 gives a single registered stage.
- Throughput: 1 operation/cycle while out_ready=1. Results leave in acceptance order with their own tag.
- Flags, computed in the final stage:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - out_zero = NOR of the full result.
- Output stability: while out_valid=1 and out_ready=0, out_sum, the flags and out_tag hold unchanged.
- Simultaneous input accept and output consume is permitted every cycle with no bubble.
- Reset asserted mid-operation discards all in-flight operations. No partial result is ever presented.
- Illegal parameters (WIDTH % BLOCK != 0) stop elaboration via a generate-time error.

Decomposition:
- Shared package alu_pkg:
  - function n_stages(width, block).
  - Flag index constants FLG_C, FLG_V, FLG_Z.
  - Packed flag typedef alu_flags_t {c, v, z}.
- Sub-module cla_block:
  - Parametrised BLOCK-bit combinational lookahead.
  - Inputs a, b, cin; outputs sum, cout, group G, group P, plus carry into its MSB for the overflow computation.
  - Instantiated once per stage via generate.

Test Plan (WIDTH=32, BLOCK=8, latency 4):
- Add 0x0000FFFF+0x00000001, cin=0, tag=3 -> 4 cycles later sum=0x00010000, c=0, v=0, z=0, tag=3.
- Add 0x7FFFFFFF+0x00000001 -> sum=0x80000000, v=1, c=0. Then 0xFFFFFFFF+0x00000001 -> sum=0, c=1, z=1, v=0.
- Sub 5-7, cin=0 -> sum=0xFFFFFFFE, c=0, v=0. Sub 0x80000000-1 -> sum=0x7FFFFFFF, v=1, c=1.
- Stream 8 back-to-back ops with tags 0..7 and out_ready=1 -> results on 8 consecutive cycles, in order, each matching a reference model.
- Hold out_ready=0 after 2 results are pending with input still offered:
  - Once the pipe fills, in_ready=0 and the outputs stay constant.
  - Release out_ready -> no loss or duplication, order preserved.
- Assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately. After release, no stale result appears within 6 cycles, and a new op returns correctly at latency 4.
